// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap consumer for the rafi core.
// Commits mepc/mcause/mtval/mstatus when a trap is taken. Then it holds flush
// for DRAIN_CYCLES and issues a one-cycle redirect to the captured target.
// The mret return path is present only when RAFI_TRAP_MRET_EN is defined.
// When the macro is undefined, mretValid is ignored.
module trap_controller #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        trapValid,
  input  logic [3:0]  trapCause,
  input  logic [31:0] trapValue,
  input  logic [31:0] trapPc,
  input  logic        mretValid,
  input  logic        csrWriteEnable,
  input  logic [11:0] csrWriteAddr,
  input  logic [31:0] csrWriteValue,
  output logic        ready,
  output logic        flush,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        mstatusMie,
  output logic        mstatusMpie
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  // Counter load value: a zero count means this is the last flush cycle.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [31:0] target_reg, target_next;
  logic [31:0] mtvec_reg, mepc_reg, mcause_reg, mtval_reg;
  logic        mie_reg, mpie_reg;
  logic        trap_accept, mret_accept;

  assign trap_accept = (state_reg == IDLE) && trapValid;

`ifdef RAFI_TRAP_MRET_EN
  // A trap that arrives in the same cycle as an mret wins, and the mret is dropped.
  assign mret_accept = (state_reg == IDLE) && mretValid && !trapValid;
`else
  logic unused_mret;
  assign unused_mret = mretValid;
  assign mret_accept = 1'b0;
`endif

  // mepc is word aligned, so the low PC bits are never stored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^trapPc[1:0];

  // Next-state logic: IDLE accepts a trap or mret, FLUSH drains, REDIRECT lasts one cycle.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    target_next = target_reg;
    case (state_reg)
      IDLE: begin
        if (trap_accept) begin
          state_next  = FLUSH;
          count_next  = DRAIN_LOAD;
          target_next = {mtvec_reg[31:2], 2'b00};
        end else if (mret_accept) begin
          state_next  = FLUSH;
          count_next  = DRAIN_LOAD;
          target_next = mepc_reg;
        end
      end
      FLUSH: begin
        if (count_reg == 4'd0) state_next = REDIRECT;
        else                   count_next = count_reg - 4'd1;
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Sequencer registers. An asynchronous reset aborts any drain that is in progress.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg  <= IDLE;
      count_reg  <= 4'd0;
      target_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      target_reg <= target_next;
    end
  end

  // CSR file. CSR writes are applied first, and trap or mret updates are
  // assigned later so they override a same-cycle write to the same register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mtvec_reg  <= 32'd0;
      mepc_reg   <= 32'd0;
      mcause_reg <= 32'd0;
      mtval_reg  <= 32'd0;
      mie_reg    <= 1'b0;
      mpie_reg   <= 1'b0;
    end else begin
      if (csrWriteEnable) begin
        case (csrWriteAddr)
          12'h300: begin
            mie_reg  <= csrWriteValue[3];
            mpie_reg <= csrWriteValue[7];
          end
          12'h305: mtvec_reg  <= {csrWriteValue[31:2], 2'b00};
          12'h341: mepc_reg   <= {csrWriteValue[31:2], 2'b00};
          12'h342: mcause_reg <= csrWriteValue;
          12'h343: mtval_reg  <= csrWriteValue;
          default: ;
        endcase
      end
      if (trap_accept) begin
        mepc_reg   <= {trapPc[31:2], 2'b00};
        mcause_reg <= {28'd0, trapCause};
        mtval_reg  <= trapValue;
        mpie_reg   <= mie_reg;
        mie_reg    <= 1'b0;
      end else if (mret_accept) begin
        mie_reg  <= mpie_reg;
        mpie_reg <= 1'b1;
      end
    end
  end

  // Every output is decoded from state or taken directly from a register.
  assign ready         = (state_reg == IDLE);
  assign flush         = (state_reg == FLUSH);
  assign redirectValid = (state_reg == REDIRECT);
  assign redirectPc    = (state_reg == REDIRECT) ? target_reg : RESET_PC;
  assign mtvec         = mtvec_reg;
  assign mepc          = mepc_reg;
  assign mcause        = mcause_reg;
  assign mtval         = mtval_reg;
  assign mstatusMie    = mie_reg;
  assign mstatusMpie   = mpie_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller. Each accepted trap or mret pushes its
// expected redirect target into a queue. The entry is popped and compared
// when the DUT raises redirectValid.
module tb_trap_controller;

  localparam int          DRAIN = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstN;
  logic        trapValid;
  logic [3:0]  trapCause;
  logic [31:0] trapValue, trapPc;
  logic        mretValid;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddr;
  logic [31:0] csrWriteValue;
  logic        ready, flush, redirectValid;
  logic [31:0] redirectPc, mtvec, mepc, mcause, mtval;
  logic        mstatusMie, mstatusMpie;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic m_mie, m_mpie;

  trap_controller #(.DRAIN_CYCLES(DRAIN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rstN(rstN),
    .trapValid(trapValid), .trapCause(trapCause), .trapValue(trapValue), .trapPc(trapPc),
    .mretValid(mretValid),
    .csrWriteEnable(csrWriteEnable), .csrWriteAddr(csrWriteAddr), .csrWriteValue(csrWriteValue),
    .ready(ready), .flush(flush), .redirectValid(redirectValid), .redirectPc(redirectPc),
    .mtvec(mtvec), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatusMie(mstatusMie), .mstatusMpie(mstatusMpie)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    csrWriteEnable = 1'b1; csrWriteAddr = a; csrWriteValue = v;
  endtask

  task automatic idle_inputs();
    trapValid = 1'b0; mretValid = 1'b0; csrWriteEnable = 1'b0;
  endtask

  // Drive a trap for the current cycle and record the expected redirect and status model.
  task automatic drive_trap(input logic [3:0] c, input logic [31:0] v, input logic [31:0] pc,
                            input logic [31:0] cur_mtvec);
    trapValid = 1'b1; trapCause = c; trapValue = v; trapPc = pc;
    sb.push_back({cur_mtvec[31:2], 2'b00});
    m_mpie = m_mie;
    m_mie  = 1'b0;
  endtask

  // Call this once the current cycle is T+start. It follows the flush until the redirect appears.
  task automatic run_to_redirect(input int start);
    int n;
    logic [31:0] exp_pc;
    n = start;
    while (redirectValid !== 1'b1 && n < 20) begin
      check1("flush_hold", flush, 1'b1);
      check1("ready_low", ready, 1'b0);
      tick();
      n++;
    end
    check("redirect_latency", 32'(n), 32'(DRAIN + 1));
    check1("redirect_valid", redirectValid, 1'b1);
    check("sb_depth", 32'(sb.size()), 32'd1);
    exp_pc = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    check("redirect_pc", redirectPc, exp_pc);
    tick();
    check1("ready_after", ready, 1'b1);
    check1("flush_after", flush, 1'b0);
    check1("redirect_drop", redirectValid, 1'b0);
  endtask

  initial begin
    bit saw_redirect;
    rstN = 1'b0; idle_inputs();
    trapCause = 4'd0; trapValue = 32'd0; trapPc = 32'd0;
    csrWriteAddr = 12'd0; csrWriteValue = 32'd0;
    m_mie = 1'b0; m_mpie = 1'b0;
    repeat (3) tick();

    // Reset state
    check1("rst_ready", ready, 1'b1);
    check1("rst_flush", flush, 1'b0);
    check1("rst_redirect", redirectValid, 1'b0);
    check("rst_redirect_pc", redirectPc, RST_PC);
    check("rst_mtvec", mtvec, 32'd0);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    check("rst_mtval", mtval, 32'd0);
    check1("rst_mie", mstatusMie, 1'b0);
    check1("rst_mpie", mstatusMpie, 1'b0);
    rstN = 1'b1;
    tick();

    // mtvec write drops the low bits
    csr_write(12'h305, 32'h8000_1003);
    tick(); idle_inputs();
    check("mtvec_align", mtvec, 32'h8000_1000);

    // Basic trap
    drive_trap(4'd2, 32'hDEAD_BEEF, 32'h8000_0104, 32'h8000_1000);
    tick(); idle_inputs();
    check("t1_mepc", mepc, 32'h8000_0104);
    check("t1_mcause", mcause, 32'd2);
    check("t1_mtval", mtval, 32'hDEAD_BEEF);
    check1("t1_mie", mstatusMie, m_mie);
    run_to_redirect(1);

    // MIE set, then a trap moves it into MPIE. The misaligned PC is aligned down.
    csr_write(12'h300, 32'h0000_0008);
    tick(); idle_inputs();
    m_mie = 1'b1; m_mpie = 1'b0;
    check1("mie_set", mstatusMie, 1'b1);
    check1("mpie_clr", mstatusMpie, 1'b0);
    drive_trap(4'd11, 32'h0, 32'h8000_0203, 32'h8000_1000);
    tick(); idle_inputs();
    check("t2_mepc", mepc, 32'h8000_0200);
    check1("t2_mpie", mstatusMpie, 1'b1);
    check1("t2_mie", mstatusMie, 1'b0);
    run_to_redirect(1);

`ifdef RAFI_TRAP_MRET_EN
    // mret restores MIE and redirects to mepc
    mretValid = 1'b1;
    sb.push_back(32'h8000_0200);
    m_mie = m_mpie; m_mpie = 1'b1;
    tick(); idle_inputs();
    check1("mret_mie", mstatusMie, 1'b1);
    check1("mret_mpie", mstatusMpie, 1'b1);
    check1("mret_flush", flush, 1'b1);
    run_to_redirect(1);
`else
    // With the macro undefined, mret is ignored.
    mretValid = 1'b1;
    tick();
    check1("mret_ign_ready", ready, 1'b1);
    check1("mret_ign_flush", flush, 1'b0);
    tick(); idle_inputs();
    check1("mret_ign_ready2", ready, 1'b1);
    check1("mret_ign_mie", mstatusMie, m_mie);
    check1("mret_ign_mpie", mstatusMpie, m_mpie);
`endif

    // A trap and an mret in the same cycle: the trap wins.
    mretValid = 1'b1;
    drive_trap(4'd7, 32'h0000_1234, 32'h8000_0300, 32'h8000_1000);
    tick(); idle_inputs();
    check("both_mcause", mcause, 32'd7);
    check("both_mepc", mepc, 32'h8000_0300);
    check1("both_mie", mstatusMie, m_mie);
    check1("both_mpie", mstatusMpie, m_mpie);
    run_to_redirect(1);
    check1("both_no_second", flush, 1'b0);

    // A trap beats a same-cycle mcause write. A write during flush is still applied.
    csr_write(12'h342, 32'h0000_0005);
    drive_trap(4'd3, 32'h0000_0042, 32'h8000_0400, 32'h8000_1000);
    tick(); idle_inputs();
    check("prio_mcause", mcause, 32'd3);
    csr_write(12'h343, 32'hCAFE_F00D);
    tick(); idle_inputs();
    check("flush_csr_mtval", mtval, 32'hCAFE_F00D);
    run_to_redirect(2);

    // A same-cycle mtvec write takes effect, but the redirect uses the old value.
    csr_write(12'h305, 32'h9000_0000);
    drive_trap(4'd4, 32'h0, 32'h8000_0500, 32'h8000_1000);
    tick(); idle_inputs();
    check("mtvec_new", mtvec, 32'h9000_0000);
    check("mtvec_mcause", mcause, 32'd4);
    run_to_redirect(1);

    // Reset during flush aborts the sequence.
    drive_trap(4'd1, 32'h0, 32'h8000_0600, 32'h9000_0000);
    tick(); idle_inputs();
    check1("pre_rst_flush", flush, 1'b1);
    rstN = 1'b0;
    #1;
    sb.delete();
    m_mie = 1'b0; m_mpie = 1'b0;
    check1("arst_flush", flush, 1'b0);
    check1("arst_ready", ready, 1'b1);
    check("arst_redirect_pc", redirectPc, RST_PC);
    check("arst_mtvec", mtvec, 32'd0);
    tick(); tick();
    rstN = 1'b1;
    saw_redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_redirect = saw_redirect | redirectValid;
    end
    check1("arst_no_redirect", saw_redirect, 1'b0);
    check1("arst_ready_after", ready, 1'b1);

    // After reset, a trap with the maximum cause goes to mtvec=0.
    drive_trap(4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    tick(); idle_inputs();
    check("post_mcause", mcause, 32'd15);
    check("post_mepc", mepc, 32'd0);
    run_to_redirect(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
